// File: rtl/pipelined_cla_addsub.sv
// Purpose : pipelined carry-lookahead adder/subtractor, one SLICE-bit lookahead slice per stage.
// Latency : N_STAGES cycles, counting the acceptance cycle. Throughput is one operation per cycle.
// Backpr. : a global stall freezes every stage while the output is held. in_ready = !out_valid || out_ready.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset; clears all valid bits and data registers
//   i_in_valid   operands present        / o_in_ready   operands accepted this cycle
//   i_a, i_b     WIDTH-bit operands (unsigned or two's complement)
//   i_cin        carry-in (add) or borrow-in (sub)
//   i_sub        0: a + b + cin, 1: a - b - cin
//   o_out_valid  result present          / i_out_ready  downstream accepts result
//   o_sum        WIDTH-bit result, modulo 2^WIDTH
//   o_cout       carry-out (add) or NOT borrow-out (sub)
//   o_ovf        signed two's-complement overflow
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N_STAGES = WIDTH / SLICE;

    // Each carry is written in flattened lookahead form:
    //   c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c0
    // so no carry depends on another carry inside the slice.
    function automatic logic [SLICE:0] cla_carry(
        input logic [SLICE-1:0] g,
        input logic [SLICE-1:0] p,
        input logic             c0
    );
        logic [SLICE:0] c;
        logic           term;
        logic           prod;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < SLICE; i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & c0);
        end
        return c;
    endfunction

    // Stage k registers hold the operation after slice k has been resolved.
    // The operands travel with the operation so later stages can take their slice.
    // The partial sum accumulates completed slices from bit 0 upward.
    // The carry register is the carry out of slice k.
    logic             r_vld [N_STAGES];
    logic [WIDTH-1:0] r_a   [N_STAGES];
    logic [WIDTH-1:0] r_b   [N_STAGES];
    logic [WIDTH-1:0] r_sum [N_STAGES];
    logic             r_c   [N_STAGES];
    logic             r_ovf;

    // Per-stage inputs: stage 0 sees the new operands, stage k sees stage k-1's registers.
    logic             w_vld_in [N_STAGES];
    logic [WIDTH-1:0] w_a_in   [N_STAGES];
    logic [WIDTH-1:0] w_b_in   [N_STAGES];
    logic [WIDTH-1:0] w_sum_in [N_STAGES];
    logic             w_c_in   [N_STAGES];

    logic             w_vld_nxt [N_STAGES];
    logic [WIDTH-1:0] w_a_nxt   [N_STAGES];
    logic [WIDTH-1:0] w_b_nxt   [N_STAGES];
    logic [WIDTH-1:0] w_sum_nxt [N_STAGES];
    logic             w_c_nxt   [N_STAGES];
    logic             w_ovf_nxt;

    logic             w_advance;

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_cc;

    assign w_advance   = !o_out_valid || i_out_ready;
    assign o_in_ready  = w_advance;

    assign o_out_valid = r_vld[N_STAGES-1];
    assign o_sum       = r_sum[N_STAGES-1];
    assign o_cout      = r_c[N_STAGES-1];
    assign o_ovf       = r_ovf;

    always_comb begin
        w_g       = '0;
        w_p       = '0;
        w_cc      = '0;
        w_ovf_nxt = 1'b0;
        for (int k = 0; k < N_STAGES; k++) begin
            w_vld_in[k]  = 1'b0;
            w_a_in[k]    = '0;
            w_b_in[k]    = '0;
            w_sum_in[k]  = '0;
            w_c_in[k]    = 1'b0;
            w_vld_nxt[k] = 1'b0;
            w_a_nxt[k]   = '0;
            w_b_nxt[k]   = '0;
            w_sum_nxt[k] = '0;
            w_c_nxt[k]   = 1'b0;
        end

        // Subtraction becomes a + ~b + ~cin. The inversion is applied here, in the
        // acceptance cycle, so every stage is a plain adder slice.
        w_vld_in[0] = i_in_valid;
        w_a_in[0]   = i_a;
        w_b_in[0]   = i_b ^ {WIDTH{i_sub}};
        w_sum_in[0] = '0;
        w_c_in[0]   = i_cin ^ i_sub;
        for (int k = 1; k < N_STAGES; k++) begin
            w_vld_in[k] = r_vld[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_sum_in[k] = r_sum[k-1];
            w_c_in[k]   = r_c[k-1];
        end

        for (int k = 0; k < N_STAGES; k++) begin
            w_g  = w_a_in[k][k*SLICE +: SLICE] & w_b_in[k][k*SLICE +: SLICE];
            w_p  = w_a_in[k][k*SLICE +: SLICE] ^ w_b_in[k][k*SLICE +: SLICE];
            w_cc = cla_carry(w_g, w_p, w_c_in[k]);

            w_vld_nxt[k] = w_vld_in[k];
            w_a_nxt[k]   = w_a_in[k];
            w_b_nxt[k]   = w_b_in[k];
            w_sum_nxt[k] = w_sum_in[k];
            w_sum_nxt[k][k*SLICE +: SLICE] = w_p ^ w_cc[SLICE-1:0];
            w_c_nxt[k]   = w_cc[SLICE];
        end

        // Overflow is resolved together with the top slice. Operand B here is
        // already conditionally inverted, so one rule covers add and sub.
        w_ovf_nxt = (w_a_in[N_STAGES-1][WIDTH-1] == w_b_in[N_STAGES-1][WIDTH-1]) &&
                    (w_sum_nxt[N_STAGES-1][WIDTH-1] != w_a_in[N_STAGES-1][WIDTH-1]);
    end

    // Bubbles advance like any other slot, so there is no per-stage enable.
    // The whole pipe moves, or the whole pipe holds.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            for (int k = 0; k < N_STAGES; k++) begin
                r_vld[k] <= w_vld_nxt[k];
                r_a[k]   <= w_a_nxt[k];
                r_b[k]   <= w_b_nxt[k];
                r_sum[k] <= w_sum_nxt[k];
                r_c[k]   <= w_c_nxt[k];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Purpose : drives a 16/4 and a 32/8 adder/subtractor in lockstep against an arithmetic reference.
// Latency : both configurations have 4 stages, so their results emerge in the same cycle.
// Backpr. : out_ready is driven both by directed sequences and randomly. The upstream holds operands while in_ready is low.
module tb_pipelined_cla_addsub;

    logic        core_clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic        rdy16, vld16, c16, o16;
    logic [15:0] s16;
    logic        rdy32, vld32, c32, o32;
    logic [31:0] s32;

    typedef struct {
        logic [15:0] s16;
        logic        c16;
        logic        o16;
        logic [31:0] s32;
        logic        c32;
        logic        o32;
        int          tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests;
    int          n_fail;
    int          n_out;
    int          adv_cnt;
    bit          prev_hold;
    bit          done;
    logic [15:0] hold16;
    logic [31:0] hold32;
    logic        hold_c16;

    pipelined_cla_addsub #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .i_clk(core_clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy16),
        .i_a(a[15:0]), .i_b(b[15:0]), .i_cin(cin), .i_sub(sub),
        .o_out_valid(vld16), .i_out_ready(out_ready),
        .o_sum(s16), .o_cout(c16), .o_ovf(o16)
    );

    pipelined_cla_addsub #(.WIDTH(32), .SLICE(8)) u_dut32 (
        .i_clk(core_clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy32),
        .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_out_valid(vld32), .i_out_ready(out_ready),
        .o_sum(s32), .o_cout(c32), .o_ovf(o32)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Integer-arithmetic reference. Returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                                           input logic cv, input logic sv);
        longint m, half, ua, ub, c, r, sa, sb, rs;
        logic   co, ov;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        c    = cv ? 1 : 0;
        if (sv) begin
            r  = ua - ub - c;
            co = (ua >= ub + c);
        end else begin
            r  = ua + ub + c;
            co = ((r >> w) & 1) != 0;
        end
        sa = (ua >= half) ? ua - (m + 1) : ua;
        sb = (ub >= half) ? ub - (m + 1) : ub;
        rs = sv ? (sa - sb - c) : (sa + sb + c);
        ov = (rs >= half) || (rs < -half);
        return {ov, co, 32'(r & m)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            5:       return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard. Transfers are decided at the negedge before the edge that performs them.
    always @(negedge core_clk) begin : mon
        exp_t        e;
        logic [33:0] r16;
        logic [33:0] r32;
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            chk("in_ready16", rdy16, !vld16 || out_ready);
            chk("in_ready32", rdy32, !vld32 || out_ready);
            chk("vld32_vs_vld16", vld32, vld16);
            if (prev_hold) begin
                chk("hold_vld", vld16, 1'b1);
                chk("hold_sum16", s16, hold16);
                chk("hold_sum32", s32, hold32);
                chk("hold_cout16", c16, hold_c16);
            end
            prev_hold = vld16 && !out_ready;
            hold16    = s16;
            hold32    = s32;
            hold_c16  = c16;
            if (vld16 && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum16", s16, e.s16);
                    chk("cout16", c16, e.c16);
                    chk("ovf16", o16, e.o16);
                    chk("sum32", s32, e.s32);
                    chk("cout32", c32, e.c32);
                    chk("ovf32", o32, e.o32);
                    chk("adv_latency", adv_cnt - e.tag, 4);
                    n_out++;
                end
            end
            if (in_valid && rdy16) begin
                r16   = ref_op(16, a, b, cin, sub);
                r32   = ref_op(32, a, b, cin, sub);
                e.s16 = r16[15:0];
                e.c16 = r16[32];
                e.o16 = r16[33];
                e.s32 = r32[31:0];
                e.c32 = r32[32];
                e.o32 = r32[33];
                e.tag = adv_cnt;
                exp_q.push_back(e);
            end
            if (!vld16 || out_ready) adv_cnt++;
        end
    end

    // Called just after a rising edge. Holds the operands until they are taken.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
        bit ok;
        ok       = 1'b0;
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge core_clk);
            if (rdy16) begin
                ok = 1'b1;
                break;
            end
            @(posedge core_clk);
            #1;
        end
        if (!ok) chk("send_timeout", 1'b0, 1'b1);
        @(posedge core_clk);
        #1;
    endtask

    // Single operation into an empty pipe with out_ready=1. Checks exact latency and result.
    task automatic dir_op(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv,
                          input logic [15:0] es, input logic ec, input logic eo, input string nm);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
        @(posedge core_clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge core_clk);
            chk({nm, "_latency"}, vld16, (i == 3));
        end
        chk({nm, "_sum"}, s16, es);
        chk({nm, "_cout"}, c16, ec);
        chk({nm, "_ovf"}, o16, eo);
        @(posedge core_clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge core_clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge core_clk);
        #1;
    endtask

    initial begin : stim
        int base;
        n_tests   = 0;
        n_fail    = 0;
        n_out     = 0;
        adv_cnt   = 0;
        prev_hold = 1'b0;
        done      = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset state
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_out_valid", vld16, 1'b0);
        chk("rst_sum16", s16, 16'h0);
        chk("rst_sum32", s32, 32'h0);
        chk("rst_cout", c16, 1'b0);
        chk("rst_ovf", o16, 1'b0);
        chk("rst_in_ready", rdy16, 1'b1);
        @(posedge core_clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed corner cases
        dir_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_chain");
        dir_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, "sub_borrow");
        dir_op(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
        dir_op(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

        // Reset mid-stream: three ops in flight are discarded
        for (int i = 0; i < 3; i++) begin
            a        = $urandom;
            b        = $urandom;
            cin      = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge core_clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge core_clk);
        #1;
        rst_n = 1'b1;
        @(negedge core_clk);
        chk("midrst_out_valid", vld16, 1'b0);
        chk("midrst_sum16", s16, 16'h0);
        chk("midrst_sum32", s32, 32'h0);
        chk("midrst_in_ready", rdy16, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge core_clk);
            chk("flush_no_output", vld16, 1'b0);
        end
        @(posedge core_clk);
        #1;

        // Backpressure: 8 back-to-back ops, out_ready low for 3 cycles mid-stream
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge core_clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge core_clk);
                    chk("bp_in_ready_low", rdy16, 1'b0);
                    chk("bp_out_valid", vld16, 1'b1);
                    @(posedge core_clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", n_out - base, 8);

        // Random traffic with random bubbles and backpressure
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge core_clk);
                        #1;
                    end
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
                done     = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge core_clk);
                    #1;
                end
            end
        join
        drain();
        chk("rand_delivered", n_out - base, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from SLICE-bit lookahead slices, one slice per pipeline stage.
- Carry ripples between stages through registers. Each stage's slice forms internal generate/propagate terms and lookahead carries.
- Sits in the datapath wherever wide add/sub must close timing at clock rate. Uses a valid/ready handshake with full-pipeline stall.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of SLICE and ≥ SLICE.
- SLICE, 4, bits resolved per pipeline stage by one lookahead slice.
- N_STAGES, WIDTH/SLICE, derived (localparam), pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: add, 1: subtract
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out (add) / NOT borrow-out (sub)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: when rst_n=0 at a rising edge, clear every stage valid bit and every pipeline data register. Outputs: out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight operations with no partial output.
- Operation:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. cout=1 means no borrow.
- ovf = (opA_msb == opB'_msb) && (sum_msb != opA_msb), where opB' is b after conditional inversion.
- Inversion of b and cin happens in the acceptance cycle, before stage 0.
- Stage k (k = 0..N_STAGES-1):
  - Computes slice k, bits [k*SLICE +: SLICE], with lookahead carry logic: g = a&b, p = a^b, c[i+1] = g[i] | p[i]&c[i].
  - Carry-in is the registered carry from stage k-1; stage 0 uses the converted cin.
  - Upper unprocessed operand slices and lower completed sum slices travel with the operation in skew registers.
- Handshake:
  - Global stall: advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_valid/out_ready only).
  - Transfer in: in_valid && in_ready at the rising edge. Transfer out: out_valid && out_ready at the rising edge.
  - When advance=0, every stage register and the output register hold their value.
  - When advance=1, each stage captures the previous stage's contents. Stage 0 captures the new operands with valid = in_valid.
  - Bubbles propagate as invalid slots and are not collapsed.
  - sum/cout/ovf are stable while out_valid=1 and out_ready=0.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+N_STAGES-1, provided there is no stall. A stall cycle adds one cycle.
- Throughput: one operation per cycle when out_ready is held at 1.
- Simultaneous events:
  - Output transfer and input acceptance in the same edge are both performed.
  - in_valid with in_ready=0: the operation is not taken; the upstream holds it.
- Wrap-around: the sum is modulo 2^WIDTH. Carry/borrow is reported only via cout.
- Invalid stages: data registers may hold stale values, but sum/cout/ovf are observed only when out_valid=1.

Test Plan:
- Reset mid-stream: issue 3 ops, assert rst_n=0 for 1 cycle -> out_valid=0, sum=0, and no result from the flushed ops ever appears.
- Add with full carry chain (WIDTH=16): a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> sum=16'h0000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Subtract with borrow-in: a=16'h0005, b=16'h0007, cin=1, sub=1 -> sum=16'hFFFD, cout=0, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, ovf=1, cout=0. Also a=16'h8000, b=16'h0001, sub -> sum=16'h7FFF, ovf=1, cout=1.
- Backpressure: stream 8 back-to-back ops, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, held output stable, all 8 results delivered in order with none lost or duplicated.
- Parameter sweep: WIDTH=32, SLICE=8, 1000 random ops with random in_valid/out_ready -> all results match a reference model, latency 4 under no stall.
